imm_extend_unit: RTL and testbench
==================================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IN_W, default 8: width of the raw immediate.
REQ-002 SHALL have parameter OUT_W, default 20: width of the extended result; legal only when OUT_W > IN_W.
REQ-003 SHALL have parameter SHIFT, default 1: left-shift amount for mode 2; legal range 0..OUT_W-IN_W.
REQ-004 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each item.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  producer presents an item.
REQ-009 in_ready  output  1  unit can accept an item this cycle.
REQ-010 in_imm  input  IN_W  raw immediate.
REQ-011 in_mode  input  2  extension mode: 0 sign, 1 zero, 2 sign then shift left, 3 upper placement.
REQ-012 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-013 out_valid  output  1  head item present.
REQ-014 out_ready  input  1  consumer accepts the head item.
REQ-015 out_data  output  OUT_W  extended result of the head item.
REQ-016 out_tag  output  TAG_W  tag of the head item.

Function
REQ-017 Transfers SHALL occur only on a rising edge where valid and ready are both 1.
REQ-018 Mode 0 SHALL produce in_imm with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
REQ-019 Mode 1 SHALL produce in_imm with zeros in bits OUT_W-1..IN_W.
REQ-020 Mode 2 SHALL produce the mode-0 result shifted left by SHIFT, with zeros shifted in and bits above OUT_W-1 discarded.
REQ-021 Mode 3 SHALL produce in_imm in bits OUT_W-1..OUT_W-IN_W, with zeros below.
REQ-022 Extension SHALL be computed at input acceptance; the stored result and tag SHALL be unaffected by later changes to in_mode or in_imm.
REQ-023 The unit SHALL buffer items in a 2-entry in-order FIFO: entry count 0, 1 or 2.
REQ-024 in_ready SHALL be 1 exactly when count < 2, derived from registered state only, with no combinational path from out_ready.
REQ-025 out_valid SHALL be 1 exactly when count > 0.
REQ-026 out_data and out_tag SHALL come from the head entry and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 Latency SHALL be 1 cycle: an item accepted at edge N is visible on the outputs after edge N.
REQ-028 Push and pop on the same edge SHALL leave count unchanged; order is preserved.
REQ-029 At count 2, in_ready SHALL be 0; an in_valid held high SHALL not be accepted until a pop frees an entry.
REQ-030 At count 0, out_ready SHALL have no effect.
REQ-031 Read and write pointers SHALL wrap modulo 2 with no gap or duplication across the wrap.

Reset
REQ-032 While rst_n=0, the unit SHALL clear count and pointers and force out_valid=0, out_data=0 and out_tag=0, independent of clk.
REQ-033 After reset release, in_ready SHALL be 1 at the first clock edge.
REQ-034 Reset asserted mid-operation SHALL discard all buffered items; no item SHALL be presented after release unless it was newly accepted.

Verification (IN_W=8, OUT_W=20, SHIFT=1)
REQ-035 Mode 0, imm 0x85, tag 3 -> one cycle later out_data=0xFFF85, out_tag=3; imm 0x7F -> 0x0007F.
REQ-036 Mode 1, imm 0x85 -> 0x00085; mode 2, imm 0x85 -> 0xFFF0A; mode 2, imm 0x7F -> 0x000FE; mode 3, imm 0x85 -> 0x85000.
REQ-037 Backpressure: out_ready=0, offer tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, in_ready=0, tag 3 stalled with out_data stable; raise out_ready -> tags 1, 2, 3 delivered in order.
REQ-038 Streaming: in_valid=1 and out_ready=1 for 8 cycles with imm 0x00..0x07 -> 8 results in order, one per cycle after the first, count never above 1.
REQ-039 Reset: fill 2 entries, pull rst_n low between clock edges -> out_valid=0 and out_data=0 immediately; after release in_ready=1 and no stale item appears.
REQ-040 Mode change: accept mode 0, imm 0x80, then switch in_mode to 1 while the item is stalled -> held out_data remains 0xFFF80.

Source files
------------

// File: rtl/imm_extend_unit_if.sv
// Item stream into and out of the immediate extension unit.
// Latency: none (wires only); groups producer and consumer handshakes.
// Backpressure: in_ready from the unit, out_ready from the consumer.
interface imm_extend_unit_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 20,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  // Environment side: produces raw items, consumes extended results.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Unit side.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Immediate extension (sign/zero/sign+shift/upper) with a 2-entry result FIFO.
// Latency: 1 cycle from input acceptance to the head of the output.
// Backpressure: in_ready drops when both entries are full; it depends on the count register only.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 20,   // must exceed IN_W
  parameter int SHIFT = 1,    // 0 .. OUT_W-IN_W
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  imm_extend_unit_if.slave bus
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic             push;
  logic             pop;

  // Ready/valid come straight from the count so there is no out_ready -> in_ready path.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q].data : '0;
  assign bus.out_tag   = bus.out_valid ? mem_q[rd_ptr_q].tag  : '0;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign sext = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};

  // Extension is computed on the incoming item so the stored result is frozen at acceptance.
  always_comb begin
    ext = '0;
    case (bus.in_mode)
      2'd0:    ext = sext;
      2'd1:    ext = {{EXT_W{1'b0}}, bus.in_imm};
      2'd2:    ext = sext << SHIFT;
      default: ext = {bus.in_imm, {EXT_W{1'b0}}};
    endcase
  end

  // Next-state for storage, pointers and occupancy; simultaneous push and pop keep count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].data = ext;
      mem_d[wr_ptr_q].tag  = bus.in_tag;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // State registers; reset discards every buffered item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit with a result scoreboard.
// Latency: expects results one cycle after acceptance.
// Backpressure: exercises stalls, streaming, reset flush and held outputs.
module tb_imm_extend_unit;
  localparam int IN_W  = 8;
  localparam int OUT_W = 20;
  localparam int SHIFT = 1;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pops;
  exp_t sb[$];

  imm_extend_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference extension written arithmetically rather than by bit replication.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    int sv;
    int r;
    sv = imm[IN_W-1] ? int'(imm) - (1 << IN_W) : int'(imm);
    case (mode)
      2'd0:    r = sv;
      2'd1:    r = int'(imm);
      2'd2:    r = sv * (1 << SHIFT);
      default: r = int'(imm) * (1 << (OUT_W - IN_W));
    endcase
    return OUT_W'(r);
  endfunction

  // Scoreboard: handshakes are judged at the falling edge, before the transferring rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'(bus.out_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(e.data));
          chk("sb_tag", 32'(bus.out_tag), 32'(e.tag));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t n;
        n.data = model(bus.in_imm, bus.in_mode);
        n.tag  = bus.in_tag;
        sb.push_back(n);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_item(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [IN_W-1:0]  imm;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] held;
    checks = 0;
    errors = 0;
    pops   = 0;
    vecs[0] = '{8'h85, 2'd0, 4'd3, 20'hFFF85};
    vecs[1] = '{8'h7F, 2'd0, 4'd4, 20'h0007F};
    vecs[2] = '{8'h85, 2'd1, 4'd5, 20'h00085};
    vecs[3] = '{8'h85, 2'd2, 4'd6, 20'hFFF0A};
    vecs[4] = '{8'h7F, 2'd2, 4'd7, 20'h000FE};
    vecs[5] = '{8'h85, 2'd3, 4'd8, 20'h85000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors: each result checked while held, then popped through the scoreboard.
    foreach (vecs[i]) begin
      push_item(vecs[i].imm, vecs[i].mode, vecs[i].tag);
      chk("vec_valid", 32'(bus.out_valid), 32'd1);
      chk("vec_data", 32'(bus.out_data), 32'(vecs[i].exp));
      chk("vec_tag", 32'(bus.out_tag), 32'(vecs[i].tag));
      pop_one();
    end
    chk("vec_empty", 32'(bus.out_valid), 32'd0);

    // Backpressure: tags 1 and 2 fill the FIFO, tag 3 stalls.
    bus.out_ready = 1'b0;
    push_item(8'h11, 2'd0, 4'd1);
    push_item(8'h92, 2'd1, 4'd2);
    bus.in_valid = 1'b1;
    bus.in_imm   = 8'hA3;
    bus.in_mode  = 2'd2;
    bus.in_tag   = 4'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_data", 32'(bus.out_data), 32'(model(8'h11, 2'd0)));
      chk("bp_hold_tag", 32'(bus.out_tag), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    begin
      int n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      chk("bp_tag3_accepted", 32'(acc), 32'd1);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Streaming: one item per cycle, occupancy never reaches 2.
    pops = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_imm  = IN_W'(i);
      bus.in_mode = 2'(i % 4);
      bus.in_tag  = TAG_W'(i);
      @(negedge clk);
      chk("st_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) chk("st_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("st_pops", 32'(pops), 32'd8);
    chk("st_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Reset mid-operation flushes both buffered entries.
    push_item(8'hC1, 2'd0, 4'd9);
    push_item(8'hC2, 2'd3, 4'd10);
    chk("rs_full", 32'(bus.in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rs_out_data", 32'(bus.out_data), 32'd0);
    chk("rs_out_tag", 32'(bus.out_tag), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rs_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Mode change after acceptance leaves the held result untouched.
    push_item(8'h80, 2'd0, 4'd5);
    bus.in_mode = 2'd1;
    bus.in_imm  = 8'h33;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mc_hold_data", 32'(bus.out_data), 32'h000FFF80);
      @(posedge clk);
      #1;
    end
    pop_one();
    chk("mc_empty", 32'(bus.out_valid), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
